// File: rtl/loader_pkg.sv
// Shared constants for the I-RAM program loader: FSM encodings, error codes,
// frame sync byte and the largest image the loader accepts.
package loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR    = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_CSUM   = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;
  localparam logic [2:0] ST_START  = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_COUNT  = 2'b01;
  localparam logic [1:0] ERR_CSUM   = 2'b10;
  localparam logic [1:0] ERR_VERIFY = 2'b11;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned MAX_WORDS = 4096;

endpackage

// File: rtl/byte_sum_acc.sv
// Clearable byte-sum accumulator. sum already includes the bytes presented this
// cycle, so a caller can compare on the same cycle the last bytes arrive.
module byte_sum_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  input  logic [3:0]  ben,
  output logic [15:0] sum
);

  logic [15:0] sum_q;
  logic [15:0] addend;

  always_comb begin
    addend = '0;
    for (int i = 0; i < 4; i++) begin
      if (ben[i]) addend = addend + {8'd0, din[8*i +: 8]};
    end
  end

  assign sum = en ? sum_q + addend : sum_q;

  always_ff @(posedge clk) begin
    if (rst || clr) sum_q <= '0;
    else            sum_q <= sum;
  end

endmodule

// File: rtl/iram_loader.sv
// Receives a framed program image, writes it to the I-RAM, reads it back to
// verify, then launches the CPU at the image start address.
//
// state  | meaning
// IDLE   | discard bytes until the sync byte
// HDR    | collect CNT_L, CNT_H, ADR_L, ADR_H and range-check CNT
// DATA   | assemble little-endian words and write them out
// CSUM   | compare the trailing 8-bit checksum
// VERIFY | read the image back and compare 16-bit byte sums
// START  | launch the CPU, flag success
// ERR    | flag failure
module iram_loader #(
  parameter int         IRAM_AW   = 12,
  parameter logic [7:0] SYNC_BYTE = loader_pkg::SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [IRAM_AW-1:0] i_ram_wadr,
  output logic [31:0]        i_ram_wdata,
  output logic               i_ram_wen,
  output logic [IRAM_AW-1:0] i_ram_radr,
  output logic               i_read_sel,
  input  logic [31:0]        i_ram_rdata,
  output logic               cpu_start,
  output logic [29:0]        start_adr,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err,
  output logic [1:0]         err_code
);
  import loader_pkg::*;

  logic [2:0]         state;
  logic [1:0]         idx;
  logic [7:0]         lo_byte;
  logic [15:0]        cnt_q;
  logic [IRAM_AW-1:0] adr_q;
  logic [IRAM_AW-1:0] wr_adr;
  logic [12:0]        words_left;
  logic [12:0]        v_left;
  logic [23:0]        word_sh;
  logic               rd_vld;
  logic               hs;
  logic               sync_hit;
  logic [15:0]        rx_sum;
  logic [15:0]        rb_sum;

  assign rx_ready   = (state == ST_IDLE) || (state == ST_HDR) ||
                      (state == ST_DATA) || (state == ST_CSUM);
  assign hs         = rx_valid && rx_ready;
  assign sync_hit   = (state == ST_IDLE) && hs && (rx_data == SYNC_BYTE);
  assign i_read_sel = (state == ST_VERIFY);
  assign load_busy  = (state != ST_IDLE);

  byte_sum_acc u_rx_sum (
    .clk (clk),
    .rst (rst),
    .clr (sync_hit),
    .en  ((state == ST_DATA) && hs),
    .din ({24'd0, rx_data}),
    .ben (4'b0001),
    .sum (rx_sum)
  );

  // Read data lags the address by one cycle, hence the delayed valid.
  byte_sum_acc u_rb_sum (
    .clk (clk),
    .rst (rst),
    .clr (sync_hit),
    .en  (rd_vld),
    .din (i_ram_rdata),
    .ben (4'b1111),
    .sum (rb_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      lo_byte     <= '0;
      cnt_q       <= '0;
      adr_q       <= '0;
      wr_adr      <= '0;
      words_left  <= '0;
      v_left      <= '0;
      word_sh     <= '0;
      rd_vld      <= 1'b0;
      i_ram_wadr  <= '0;
      i_ram_wdata <= '0;
      i_ram_wen   <= 1'b0;
      i_ram_radr  <= '0;
      cpu_start   <= 1'b0;
      start_adr   <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      i_ram_wen <= 1'b0;
      cpu_start <= 1'b0;
      rd_vld    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync_hit) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= ERR_NONE;
            idx       <= '0;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (hs) begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0: lo_byte <= rx_data;
              2'd1: cnt_q   <= {rx_data, lo_byte};
              2'd2: lo_byte <= rx_data;
              default: begin
                adr_q      <= {rx_data[IRAM_AW-9:0], lo_byte};
                wr_adr     <= {rx_data[IRAM_AW-9:0], lo_byte};
                words_left <= cnt_q[12:0];
                if (cnt_q == 16'd0 || {16'd0, cnt_q} > MAX_WORDS) begin
                  err_code <= ERR_COUNT;
                  state    <= ST_ERR;
                end else begin
                  state <= ST_DATA;
                end
              end
            endcase
          end
        end
        ST_DATA: begin
          if (hs) begin
            idx     <= idx + 2'd1;
            word_sh <= {rx_data, word_sh[23:8]};
            if (idx == 2'd3) begin
              i_ram_wdata <= {rx_data, word_sh};
              i_ram_wadr  <= wr_adr;
              i_ram_wen   <= 1'b1;
              wr_adr      <= wr_adr + 1'b1;
              words_left  <= words_left - 13'd1;
              if (words_left == 13'd1) state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (hs) begin
            if (rx_data != rx_sum[7:0]) begin
              err_code <= ERR_CSUM;
              state    <= ST_ERR;
            end else begin
              v_left     <= cnt_q[12:0];
              i_ram_radr <= adr_q;
              state      <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (v_left != 13'd0) begin
            rd_vld <= 1'b1;
            v_left <= v_left - 13'd1;
            if (v_left != 13'd1) i_ram_radr <= i_ram_radr + 1'b1;
          end else if (rb_sum != rx_sum) begin
            err_code <= ERR_VERIFY;
            state    <= ST_ERR;
          end else begin
            state <= ST_START;
          end
        end
        ST_START: begin
          cpu_start <= 1'b1;
          start_adr <= 30'(adr_q);
          load_done <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_ERR: begin
          load_err <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: a table of frames with hand-computed
// outcomes, an I-RAM model with a readback fault hook, and reset corner cases.
module tb_iram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] i_ram_wadr;
  logic [31:0] i_ram_wdata;
  logic        i_ram_wen;
  logic [11:0] i_ram_radr;
  logic        i_read_sel;
  logic [31:0] i_ram_rdata;
  logic        cpu_start;
  logic [29:0] start_adr;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  iram_loader #(.IRAM_AW(12), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .i_ram_wadr  (i_ram_wadr),
    .i_ram_wdata (i_ram_wdata),
    .i_ram_wen   (i_ram_wen),
    .i_ram_radr  (i_ram_radr),
    .i_read_sel  (i_read_sel),
    .i_ram_rdata (i_ram_rdata),
    .cpu_start   (cpu_start),
    .start_adr   (start_adr),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // I-RAM model: one-cycle read latency, optional bit-0 flip on 2nd readback
  logic [31:0] mem [4096];
  int          rd_issue = 0;
  bit          flip_en = 1'b0;
  always @(posedge clk) begin
    if (i_ram_wen) mem[i_ram_wadr] <= i_ram_wdata;
    i_ram_rdata <= mem[i_ram_radr] ^ {31'd0, flip_en && i_read_sel && rd_issue == 1};
    rd_issue    <= i_read_sel ? rd_issue + 1 : 0;
  end

  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [11:0] ra_q[$];
  int          n_start = 0;
  int          start_cyc = 0;
  int          overlap = 0;
  logic [29:0] start_seen = '0;
  always @(negedge clk) begin
    if (i_ram_wen) begin
      wa_q.push_back(i_ram_wadr);
      wd_q.push_back(i_ram_wdata);
      if (i_read_sel) overlap++;
    end
    if (i_read_sel) ra_q.push_back(i_ram_radr);
    if (cpu_start) begin
      n_start++;
      start_cyc  = cyc;
      start_seen = start_adr;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] adr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum_delta;
    bit          flip;
    bit          stall;
    bit          pre_reset;
    bit          exp_done;
    logic [1:0]  exp_code;
    int          exp_writes;
  } vec_t;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // hs returns the edge count of the last accepted frame byte
  task automatic send_frame(input vec_t v, output int hs);
    logic [7:0]  sum = 8'd0;
    logic [7:0]  b;
    logic [31:0] w;
    send_byte(8'h3C);
    send_byte(8'hA5);
    send_byte(v.cnt[7:0]);
    send_byte(v.cnt[15:8]);
    send_byte(v.adr[7:0]);
    send_byte(v.adr[15:8]);
    hs = cyc;
    if (v.cnt != 16'd0 && v.cnt <= 16'd2) begin
      for (int i = 0; i < int'(v.cnt); i++) begin
        w = (i == 0) ? v.w0 : v.w1;
        for (int j = 0; j < 4; j++) begin
          b = w[8*j +: 8];
          send_byte(b);
          sum = sum + b;
          if (v.stall && i == 0 && j == 1) begin
            repeat (5) @(posedge clk);
            #1;
          end
        end
      end
      send_byte(sum + v.csum_delta);
      hs = cyc;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (load_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (load_busy) check("idle_timeout", load_busy, 0);
  endtask

  task automatic mid_reset();
    int bw = wa_q.size();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_rx_ready", rx_ready, 1);
    check("mr_busy", load_busy, 0);
    check("mr_wen", i_ram_wen, 0);
    check("mr_read_sel", i_read_sel, 0);
    check("mr_start_adr", start_adr, 0);
    check("mr_err", {load_done, load_err, err_code}, 0);
    send_byte(8'hCC);
    send_byte(8'hDD);
    repeat (3) @(negedge clk);
    check("mr_no_write", wa_q.size() - bw, 0);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   hs, bw, br, bs, bo, er;

  initial begin
    vecs[0] = '{16'd2,      16'h0010, 32'h00000013, 32'h0000006F, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2};
    vecs[1] = '{16'd2,      16'h0FFF, 32'hDEADBEEF, 32'h01020304, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2};
    vecs[2] = '{16'd2,      16'h0010, 32'h00000013, 32'h0000006F, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2};
    vecs[3] = '{16'd0,      16'h0010, 32'h0,        32'h0,        8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 0};
    vecs[4] = '{16'h1001,   16'h0010, 32'h0,        32'h0,        8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 0};
    vecs[5] = '{16'd2,      16'h0020, 32'h11223344, 32'h55667788, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2};
    vecs[6] = '{16'd2,      16'h0100, 32'hCAFEF00D, 32'h0BADC0DE, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2};
    vecs[7] = '{16'd1,      16'h07FF, 32'hA5A5A5A5, 32'h0,        8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_busy", load_busy, 0);
    check("rst_flags", {load_done, load_err, err_code, cpu_start}, 0);
    check("rst_ram_ctl", {i_ram_wen, i_read_sel, i_ram_wadr, i_ram_radr}, 0);
    check("rst_start_adr", start_adr, 0);

    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      if (v.pre_reset) mid_reset();
      flip_en = v.flip;
      bw = wa_q.size();
      br = ra_q.size();
      bs = n_start;
      bo = overlap;
      send_frame(v, hs);
      wait_idle();
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_done", k), load_done, v.exp_done);
      check($sformatf("v%0d_err", k), load_err, v.exp_code != 2'b00);
      check($sformatf("v%0d_code", k), err_code, v.exp_code);
      check($sformatf("v%0d_starts", k), n_start - bs, v.exp_done);
      check($sformatf("v%0d_nwrites", k), wa_q.size() - bw, v.exp_writes);
      check($sformatf("v%0d_overlap", k), overlap - bo, 0);
      for (int i = 0; i < v.exp_writes && bw + i < wa_q.size(); i++) begin
        check($sformatf("v%0d_wadr%0d", k, i), wa_q[bw+i], 12'(v.adr[11:0] + 12'(i)));
        check($sformatf("v%0d_wdata%0d", k, i), wd_q[bw+i], (i == 0) ? v.w0 : v.w1);
      end
      er = (v.exp_code == 2'b00 || v.exp_code == 2'b11) ? int'(v.cnt) : 0;
      check($sformatf("v%0d_read_cycles", k), ra_q.size() - br, (er == 0) ? 0 : er + 1);
      for (int i = 0; i < er && br + i < ra_q.size(); i++)
        check($sformatf("v%0d_radr%0d", k, i), ra_q[br+i], 12'(v.adr[11:0] + 12'(i)));
      if (v.exp_done) begin
        check($sformatf("v%0d_start_adr", k), start_seen, {18'd0, v.adr[11:0]});
        // pulse cycle begins cnt+2 edges after the edge that took CSUM
        check($sformatf("v%0d_latency", k), start_cyc - hs, int'(v.cnt) + 2);
      end
    end

    // reset landing on the START cycle must swallow the launch pulse
    v = vecs[0];
    v.adr = 16'h0040;
    flip_en = 1'b0;
    bs = n_start;
    send_frame(v, hs);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rs_cpu_start", cpu_start, 0);
    repeat (4) @(negedge clk);
    check("rs_no_pulse", n_start - bs, 0);
    check("rs_done", load_done, 0);
    check("rs_busy", load_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d limit=50000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
